div_op_seq: RTL and testbench



---
 rtl/alu_pkg.sv | 17 +
 rtl/div_step.sv | 33 +++
 rtl/div_op_seq.sv | 158 +++++++++++++++
 tb/tb_div_op_seq.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: divider state encoding, default datapath width and
// the DIV opcode decoded by the control unit.
package alu_pkg;

  localparam int DIV_WIDTH = 32;

  // DIV opcode as seen by the control unit.
  localparam logic [5:0] OP_DIV = 6'h1A;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One restoring-division step: shift {R,Q} left by one, try R - D, and keep
// the difference (quotient bit 1) only when it is non-negative.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH:0]   r_in,
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH-1:0] d_in,
  output logic [WIDTH:0]   r_out,
  output logic [WIDTH-1:0] q_out
);

  // The shift is kept one bit wider than R so the borrow out of the trial
  // subtraction is exact even though R never exceeds D in practice.
  logic [WIDTH+1:0] r_sh;
  logic [WIDTH+1:0] trial;
  logic [WIDTH-1:0] q_sh;

  // Trial subtraction and restore decision.
  always_comb begin
    r_sh  = {r_in, q_in[WIDTH-1]};
    q_sh  = {q_in[WIDTH-2:0], 1'b0};
    trial = r_sh - {2'b00, d_in};
    if (!trial[WIDTH+1]) begin
      r_out = trial[WIDTH:0];
      q_out = {q_sh[WIDTH-1:1], 1'b1};
    end else begin
      r_out = r_sh[WIDTH:0];
      q_out = q_sh;
    end
  end

endmodule

// File: rtl/div_op_seq.sv
// Multi-cycle signed restoring divider. Quotient truncates toward zero and
// goes to LO; remainder takes the dividend's sign and goes to HI.
//
// Handshake: start is sampled only while IDLE; the operands are captured on
// that same edge. busy is high for the WIDTH+1 cycles of CALC and FIX, then
// done pulses for exactly one cycle with quo_out/rem_out/div_by_zero valid
// from that cycle until the next completed operation. A zero divisor skips
// the iteration and pulses done in the cycle right after the accept.
module div_op_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A_reg,
  input  logic [WIDTH-1:0] B_reg,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quo_out,
  output logic [WIDTH-1:0] rem_out,
  output logic [1:0]       state_dbg
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic             sign_a_q, sign_a_d;
  logic             sign_x_q, sign_x_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   step_r;
  logic [WIDTH-1:0] step_q;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  div_step #(.WIDTH(WIDTH)) u_step (
    .r_in  (r_q),
    .q_in  (q_q),
    .d_in  (d_q),
    .r_out (step_r),
    .q_out (step_q)
  );

  // Operand magnitudes; the most negative value maps to 2^(WIDTH-1) unsigned.
  always_comb begin
    a_mag = A_reg[WIDTH-1] ? -A_reg : A_reg;
    b_mag = B_reg[WIDTH-1] ? -B_reg : B_reg;
  end

  // Next-state, datapath and registered-output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    r_d      = r_q;
    q_d      = q_q;
    d_d      = d_q;
    sign_a_d = sign_a_q;
    sign_x_d = sign_x_q;
    quo_d    = quo_q;
    rem_d    = rem_q;
    dbz_d    = dbz_q;
    busy_d   = 1'b0;
    done_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (B_reg == '0) begin
            state_d = ST_DONE;
            quo_d   = '0;
            rem_d   = A_reg;
            dbz_d   = 1'b1;
            done_d  = 1'b1;
          end else begin
            state_d  = ST_CALC;
            q_d      = a_mag;
            d_d      = b_mag;
            r_d      = '0;
            cnt_d    = '0;
            sign_a_d = A_reg[WIDTH-1];
            sign_x_d = A_reg[WIDTH-1] ^ B_reg[WIDTH-1];
            busy_d   = 1'b1;
          end
        end
      end
      ST_CALC: begin
        r_d    = step_r;
        q_d    = step_q;
        cnt_d  = cnt_q + CNT_ONE;
        busy_d = 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        quo_d   = sign_x_q ? -q_q : q_q;
        rem_d   = sign_a_q ? -r_q[WIDTH-1:0] : r_q[WIDTH-1:0];
        dbz_d   = 1'b0;
        state_d = ST_DONE;
        done_d  = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // All state and outputs; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      r_q      <= '0;
      q_q      <= '0;
      d_q      <= '0;
      sign_a_q <= 1'b0;
      sign_x_q <= 1'b0;
      quo_q    <= '0;
      rem_q    <= '0;
      dbz_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      r_q      <= r_d;
      q_q      <= q_d;
      d_q      <= d_d;
      sign_a_q <= sign_a_d;
      sign_x_q <= sign_x_d;
      quo_q    <= quo_d;
      rem_q    <= rem_d;
      dbz_q    <= dbz_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign quo_out     = quo_q;
  assign rem_out     = rem_q;
  assign state_dbg   = state_q;

endmodule

// File: tb/tb_div_op_seq.sv
// Bench for div_op_seq: scenario tasks driving a result scoreboard.
module tb_div_op_seq;

  localparam int W       = 32;
  localparam int LAT_MAX = 60;
  localparam logic [W-1:0] MIN_V = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] NEG1  = {W{1'b1}};

  logic         clk;
  logic         clr_n;
  logic         start;
  logic [W-1:0] A_reg;
  logic [W-1:0] B_reg;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [W-1:0] quo_out;
  logic [W-1:0] rem_out;
  logic [1:0]   state_dbg;

  int checks;
  int errors;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_r[$];
  logic         exp_z[$];

  div_op_seq #(.WIDTH(W)) dut (
    .clk         (clk),
    .clr_n       (clr_n),
    .start       (start),
    .A_reg       (A_reg),
    .B_reg       (B_reg),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .quo_out     (quo_out),
    .rem_out     (rem_out),
    .state_dbg   (state_dbg)
  );

  // Clock and initial reset values.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference model built on the language's signed division operators.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic z);
    logic signed [W-1:0] sa;
    logic signed [W-1:0] sb;
    sa = a;
    sb = b;
    if (b == '0) begin
      q = '0; r = a; z = 1'b1;
    end else if (a == MIN_V && b == NEG1) begin
      q = MIN_V; r = '0; z = 1'b0;
    end else begin
      q = sa / sb; r = sa % sb; z = 1'b0;
    end
  endfunction

  // Driver: queue the expected result, pulse start, wait (bounded) for done.
  // Returns at the negedge where done is seen, lat = cycles since accept.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output int busy_cnt, output bit overlap);
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         ez;
    model(a, b, eq, er, ez);
    exp_q.push_back(eq);
    exp_r.push_back(er);
    exp_z.push_back(ez);
    @(negedge clk);
    A_reg = a;
    B_reg = b;
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    lat      = -1;
    busy_cnt = 0;
    overlap  = 1'b0;
    for (int k = 1; k <= LAT_MAX; k++) begin
      if (busy) busy_cnt++;
      if (busy && done) overlap = 1'b1;
      if (done) begin
        lat = k;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    clr_n = 1'b0;
    start = 1'b0;
    A_reg = '0;
    B_reg = '0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL reset_dbz got=%b exp=0", div_by_zero); end
    checks++; if (quo_out !== '0) begin errors++; $display("FAIL reset_quo got=%h exp=0", quo_out); end
    checks++; if (rem_out !== '0) begin errors++; $display("FAIL reset_rem got=%h exp=0", rem_out); end
    checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", state_dbg); end
    clr_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_signed_cases();
    logic [W-1:0] ta[7];
    logic [W-1:0] tb[7];
    int lat, bc;
    bit ov;
    logic [W-1:0] e;
    logic ez;
    ta[0] = 32'd100;        tb[0] = 32'd7;
    ta[1] = -32'sd100;      tb[1] = 32'd7;
    ta[2] = 32'd100;        tb[2] = -32'sd7;
    ta[3] = -32'sd100;      tb[3] = -32'sd7;
    ta[4] = MIN_V;          tb[4] = NEG1;
    ta[5] = MIN_V;          tb[5] = 32'd1;
    ta[6] = 32'd5;          tb[6] = 32'd9;
    for (int i = 0; i < 7; i++) begin
      run_op(ta[i], tb[i], lat, bc, ov);
      checks++; if (lat !== W + 2) begin errors++; $display("FAIL signed_lat[%0d] got=%0d exp=%0d", i, lat, W + 2); end
      checks++; if (bc !== W + 1) begin errors++; $display("FAIL signed_busy[%0d] got=%0d exp=%0d", i, bc, W + 1); end
      checks++; if (ov !== 1'b0) begin errors++; $display("FAIL signed_overlap[%0d] got=%b exp=0", i, ov); end
      e = exp_q.pop_front();
      checks++; if (quo_out !== e) begin errors++; $display("FAIL signed_quo[%0d] got=%h exp=%h", i, quo_out, e); end
      e = exp_r.pop_front();
      checks++; if (rem_out !== e) begin errors++; $display("FAIL signed_rem[%0d] got=%h exp=%h", i, rem_out, e); end
      ez = exp_z.pop_front();
      checks++; if (div_by_zero !== ez) begin errors++; $display("FAIL signed_dbz[%0d] got=%b exp=%b", i, div_by_zero, ez); end
    end
  endtask

  task automatic test_div_zero();
    int lat, bc;
    bit ov;
    logic [W-1:0] e;
    logic ez;
    run_op(32'd7, 32'd0, lat, bc, ov);
    checks++; if (lat !== 1) begin errors++; $display("FAIL dz_lat got=%0d exp=1", lat); end
    checks++; if (bc !== 0) begin errors++; $display("FAIL dz_busy got=%0d exp=0", bc); end
    e = exp_q.pop_front();
    checks++; if (quo_out !== e) begin errors++; $display("FAIL dz_quo got=%h exp=%h", quo_out, e); end
    e = exp_r.pop_front();
    checks++; if (rem_out !== e) begin errors++; $display("FAIL dz_rem got=%h exp=%h", rem_out, e); end
    ez = exp_z.pop_front();
    checks++; if (div_by_zero !== ez) begin errors++; $display("FAIL dz_flag got=%b exp=%b", div_by_zero, ez); end
    run_op(32'd9, 32'd3, lat, bc, ov);
    checks++; if (lat !== W + 2) begin errors++; $display("FAIL dz_after_lat got=%0d exp=%0d", lat, W + 2); end
    e = exp_q.pop_front();
    checks++; if (quo_out !== e) begin errors++; $display("FAIL dz_after_quo got=%h exp=%h", quo_out, e); end
    e = exp_r.pop_front();
    checks++; if (rem_out !== e) begin errors++; $display("FAIL dz_after_rem got=%h exp=%h", rem_out, e); end
    ez = exp_z.pop_front();
    checks++; if (div_by_zero !== ez) begin errors++; $display("FAIL dz_after_flag got=%b exp=%b", div_by_zero, ez); end
  endtask

  // start re-pulsed in CALC, FIX (with a zero divisor) and DONE must be ignored.
  task automatic test_ignore_start();
    int lat;
    logic [W-1:0] eq;
    logic [W-1:0] er;
    logic         ez;
    model(32'd100, 32'd7, eq, er, ez);
    exp_q.push_back(eq);
    exp_r.push_back(er);
    exp_z.push_back(ez);
    @(negedge clk);
    A_reg = 32'd100;
    B_reg = 32'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = -1;
    for (int k = 1; k <= LAT_MAX; k++) begin
      if (done) begin
        lat = k;
      end
      start = 1'b0;
      if (k == 5 || k == W) begin
        A_reg = 32'd1234; B_reg = 32'd5; start = 1'b1;
      end else if (k == W + 1) begin
        A_reg = 32'd77; B_reg = 32'd0; start = 1'b1;
      end else if (k == W + 2) begin
        A_reg = 32'd999; B_reg = 32'd3; start = 1'b1;
      end
      if (lat != -1) break;
      @(negedge clk);
    end
    checks++; if (lat !== W + 2) begin errors++; $display("FAIL ign_lat got=%0d exp=%0d", lat, W + 2); end
    eq = exp_q.pop_front();
    er = exp_r.pop_front();
    ez = exp_z.pop_front();
    checks++; if (quo_out !== eq) begin errors++; $display("FAIL ign_quo got=%h exp=%h", quo_out, eq); end
    checks++; if (rem_out !== er) begin errors++; $display("FAIL ign_rem got=%h exp=%h", rem_out, er); end
    checks++; if (div_by_zero !== ez) begin errors++; $display("FAIL ign_dbz got=%b exp=%b", div_by_zero, ez); end
    @(negedge clk);
    start = 1'b0;
    checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL ign_idle_state got=%0d exp=0", state_dbg); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ign_idle_busy got=%b exp=0", busy); end
  endtask

  task automatic test_back_to_back();
    int lat, bc;
    bit ov;
    logic [W-1:0] e;
    logic [W-1:0] ba[3];
    logic [W-1:0] bb[3];
    ba[0] = 32'd1000; bb[0] = 32'd33;
    ba[1] = -32'sd55; bb[1] = 32'd6;
    ba[2] = 32'd3;    bb[2] = 32'd0;
    for (int i = 0; i < 3; i++) begin
      run_op(ba[i], bb[i], lat, bc, ov);
      checks++; if (lat !== ((bb[i] == '0) ? 1 : W + 2)) begin errors++; $display("FAIL b2b_lat[%0d] got=%0d", i, lat); end
      e = exp_q.pop_front();
      checks++; if (quo_out !== e) begin errors++; $display("FAIL b2b_quo[%0d] got=%h exp=%h", i, quo_out, e); end
      e = exp_r.pop_front();
      checks++; if (rem_out !== e) begin errors++; $display("FAIL b2b_rem[%0d] got=%h exp=%h", i, rem_out, e); end
      void'(exp_z.pop_front());
    end
  endtask

  task automatic test_reset_mid();
    int lat, bc;
    bit ov;
    bit saw_done;
    logic [W-1:0] e;
    @(negedge clk);
    A_reg = 32'd100;
    B_reg = 32'd7;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    clr_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got=%b exp=0", busy); end
    checks++; if (quo_out !== '0) begin errors++; $display("FAIL rmid_quo got=%h exp=0", quo_out); end
    checks++; if (rem_out !== '0) begin errors++; $display("FAIL rmid_rem got=%h exp=0", rem_out); end
    checks++; if (state_dbg !== 2'd0) begin errors++; $display("FAIL rmid_state got=%0d exp=0", state_dbg); end
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    clr_n = 1'b1;
    for (int k = 0; k < W + 4; k++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL rmid_no_done got=%b exp=0", saw_done); end
    run_op(32'd100, 32'd7, lat, bc, ov);
    checks++; if (lat !== W + 2) begin errors++; $display("FAIL rmid_lat got=%0d exp=%0d", lat, W + 2); end
    e = exp_q.pop_front();
    checks++; if (quo_out !== e) begin errors++; $display("FAIL rmid_quo2 got=%h exp=%h", quo_out, e); end
    e = exp_r.pop_front();
    checks++; if (rem_out !== e) begin errors++; $display("FAIL rmid_rem2 got=%h exp=%h", rem_out, e); end
    void'(exp_z.pop_front());
  endtask

  task automatic test_random();
    int lat, bc;
    bit ov;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] e;
    logic ez;
    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      if ($urandom_range(0, 19) == 0) a = MIN_V;
      case ($urandom_range(0, 9))
        0: b = '0;
        1: b = NEG1;
        2, 3: begin
          b = W'($urandom_range(1, 15));
          if ($urandom_range(0, 1) == 1) b = -b;
        end
        default: b = $urandom;
      endcase
      run_op(a, b, lat, bc, ov);
      checks++; if (lat !== ((b == '0) ? 1 : W + 2)) begin errors++; $display("FAIL rnd_lat[%0d] a=%h b=%h got=%0d", i, a, b, lat); end
      e = exp_q.pop_front();
      checks++; if (quo_out !== e) begin errors++; $display("FAIL rnd_quo[%0d] a=%h b=%h got=%h exp=%h", i, a, b, quo_out, e); end
      e = exp_r.pop_front();
      checks++; if (rem_out !== e) begin errors++; $display("FAIL rnd_rem[%0d] a=%h b=%h got=%h exp=%h", i, a, b, rem_out, e); end
      ez = exp_z.pop_front();
      checks++; if (div_by_zero !== ez) begin errors++; $display("FAIL rnd_dbz[%0d] a=%h b=%h got=%b exp=%b", i, a, b, div_by_zero, ez); end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_signed_cases();
    test_div_zero();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
